// File: rtl/framer_ctrl_param_if.sv
// Symbol/marker handshake and framer status bundle between the marker detector side and the framer.
// loss_cnt exists only when FRAMER_STATS_EN is defined.
interface framer_ctrl_param_if #(
  parameter int CW     = 3,
  parameter int STAT_W = 8
);
  logic              en;
  logic              sync_flag;
  logic              sof;
  logic [1:0]        state;
  logic [CW-1:0]     pos;
  logic              locked;
`ifdef FRAMER_STATS_EN
  logic [STAT_W-1:0] loss_cnt;

  modport master (output en, sync_flag, input sof, state, pos, locked, loss_cnt);
  modport slave  (input en, sync_flag, output sof, state, pos, locked, loss_cnt);
`else
  modport master (output en, sync_flag, input sof, state, pos, locked);
  modport slave  (input en, sync_flag, output sof, state, pos, locked);
`endif
endinterface

// File: rtl/framer_ctrl_param.sv
// Frame-sync controller: SEARCH -> CONFIRM -> SYNC with programmable confirm and flywheel depth.
// Optional lock-loss statistics counter enabled by defining FRAMER_STATS_EN.
module framer_ctrl_param #(
  parameter int FRAME_SIZE = 8,
  parameter int CONFIRM_N  = 2,
  parameter int LOSS_N     = 3,
  parameter int STAT_W     = 8
) (
  input logic                clk,
  input logic                reset,
  framer_ctrl_param_if.slave bus
);
  localparam int CW  = $clog2(FRAME_SIZE);
  localparam int CCW = (CONFIRM_N > 1) ? $clog2(CONFIRM_N) : 1;
  localparam int LCW = (LOSS_N > 1) ? $clog2(LOSS_N) : 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    CONFIRM = 2'b01,
    SYNC    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  pos_q, pos_d, pos_inc;
  logic [CCW-1:0] conf_q, conf_d;
  logic [LCW-1:0] miss_q, miss_d;
  logic           bnd;

  assign pos_inc = (pos_q == CW'(FRAME_SIZE - 1)) ? '0 : pos_q + 1'b1;
  assign bnd     = bus.en && (pos_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      pos_q   <= '0;
      conf_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      conf_q  <= conf_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    conf_d  = conf_q;
    miss_d  = miss_q;
    case (state_q)
      SEARCH: begin
        // The marker symbol itself is position 0, so the next symbol is position 1.
        if (bus.en && bus.sync_flag) begin
          state_d = CONFIRM;
          pos_d   = CW'(1);
          conf_d  = '0;
        end
      end
      CONFIRM: begin
        if (bus.en) pos_d = pos_inc;
        if (bnd) begin
          if (!bus.sync_flag) begin
            state_d = SEARCH;
            pos_d   = '0;
          end else if (conf_q == CCW'(CONFIRM_N - 1)) begin
            state_d = SYNC;
            miss_d  = '0;
          end else begin
            conf_d = conf_q + 1'b1;
          end
        end
      end
      SYNC: begin
        if (bus.en) pos_d = pos_inc;
        if (bnd) begin
          if (bus.sync_flag) begin
            miss_d = '0;
          end else if (miss_q == LCW'(LOSS_N - 1)) begin
            state_d = SEARCH;
            pos_d   = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: begin
        // Unreachable encoding recovers unconditionally, even with en low.
        state_d = SEARCH;
        pos_d   = '0;
      end
    endcase
  end

  assign bus.sof    = (state_q == SYNC) && bnd;
  assign bus.state  = state_q;
  assign bus.pos    = pos_q;
  assign bus.locked = (state_q == SYNC);

`ifdef FRAMER_STATS_EN
  logic [STAT_W-1:0] loss_q;

  always_ff @(posedge clk) begin
    if (reset)
      loss_q <= '0;
    else if (state_q == SYNC && state_d == SEARCH && loss_q != '1)
      loss_q <= loss_q + 1'b1;
  end

  assign bus.loss_cnt = loss_q;
`endif
endmodule
